// File: rtl/line_buffer_feeder.sv
// line_buffer_feeder
//   Walks an image in bands of KER_SIZE rows and streams one KER_SIZE-pixel
//   column per cycle into a KxK line-buffer window array. Each presented
//   column carries a rotating col_ptr (c mod K) and a saturating
//   init_col_ptr (min(c, K-1)). win_valid marks the cycle in which the
//   array's output register holds a new full window.
//
//   Build option: define LB_FEEDER_STRIDE2_EN for stride-2 operation
//   (row step 2, windows only on columns with (c-(K-1)) even).
//
// Ports
//   clk, rstn          clock; asynchronous active-low reset
//   start              frame start pulse (ignored while busy)
//   img_w, img_h       image size, latched on an accepted start
//   stall              holds off new column reads (same-cycle gate)
//   rd_en/rd_row/rd_col column read request; rd_data returns 1 cycle later
//   pixel_out          presented column (slice j = row rd_row+j)
//   col_ptr            c mod K of the presented column
//   init_col_ptr       min(c, K-1) of the presented column
//   col_vld            new column presented this cycle
//   win_valid          window array registered a new full window
//   busy, done         frame in progress / one-cycle end-of-frame pulse
module line_buffer_feeder #(
  parameter int KER_SIZE = 3,
  parameter int BITWIDTH = 8,
  parameter int AW       = 8
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         start,
  input  logic [AW-1:0]                img_w,
  input  logic [AW-1:0]                img_h,
  input  logic                         stall,
  output logic                         rd_en,
  output logic [AW-1:0]                rd_row,
  output logic [AW-1:0]                rd_col,
  input  logic [BITWIDTH*KER_SIZE-1:0] rd_data,
  output logic [BITWIDTH*KER_SIZE-1:0] pixel_out,
  output logic [2:0]                   col_ptr,
  output logic [2:0]                   init_col_ptr,
  output logic                         col_vld,
  output logic                         win_valid,
  output logic                         busy,
  output logic                         done
);

`ifdef LB_FEEDER_STRIDE2_EN
  localparam int ROW_STEP = 2;
`else
  localparam int ROW_STEP = 1;
`endif
  localparam logic [2:0]  KM1 = 3'(KER_SIZE - 1);
  localparam logic [AW:0] KW  = (AW+1)'(KER_SIZE);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  // Column tag carried alongside an in-flight read.
  typedef struct packed {
    logic [AW-1:0] c;
    logic [2:0]    cm;
  } col_tag_t;

  state_t        state, state_nx;
  logic [AW-1:0] w_q, h_q, r_q, c_q;
  logic [2:0]    cm_q;          // running c mod K, avoids a divider
  col_tag_t      tag_s1;
  logic [1:0]    vld_pipe;      // [0]: read in flight, [1]: column presented
  logic          issue, last_col, last_band, dims_ok, win_nx;

  assign dims_ok   = ({1'b0, img_w} >= KW) && ({1'b0, img_h} >= KW);
  assign issue     = (state == RUN) && !stall;
  assign last_col  = (c_q == w_q - 1'b1);
  // Last band: no further full band fits below the current one.
  assign last_band = ({1'b0, r_q} + (AW+1)'(ROW_STEP)) > ({1'b0, h_q} - KW);

  assign rd_en   = issue;
  assign rd_row  = r_q;
  assign rd_col  = c_q;
  assign col_vld = vld_pipe[1];
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start) state_nx = dims_ok ? RUN : DONE;
      RUN:   if (issue && last_col && last_band) state_nx = DRAIN;
      // Leave once nothing is in flight and no window is still to be flagged.
      DRAIN: if (!vld_pipe[0] && !(col_vld && init_col_ptr == KM1)) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      w_q   <= '0;
      h_q   <= '0;
      r_q   <= '0;
      c_q   <= '0;
      cm_q  <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start && dims_ok) begin
        w_q  <= img_w;
        h_q  <= img_h;
        r_q  <= '0;
        c_q  <= '0;
        cm_q <= '0;
      end else if (issue) begin
        if (last_col) begin
          c_q  <= '0;
          cm_q <= '0;
          r_q  <= r_q + AW'(ROW_STEP);
        end else begin
          c_q  <= c_q + 1'b1;
          cm_q <= (cm_q == KM1) ? 3'd0 : cm_q + 3'd1;
        end
      end
    end
  end

`ifdef LB_FEEDER_STRIDE2_EN
  logic c_par;                  // LSB of the presented column index
  assign win_nx = col_vld && (init_col_ptr == KM1) && (c_par == KM1[0]);
`else
  assign win_nx = col_vld && (init_col_ptr == KM1);
`endif

  // Presentation outputs only move when a column returns, so an idle
  // cycle re-presents the previous column (harmless to the window array).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_pipe     <= '0;
      tag_s1       <= '0;
      pixel_out    <= '0;
      col_ptr      <= '0;
      init_col_ptr <= '0;
      win_valid    <= 1'b0;
`ifdef LB_FEEDER_STRIDE2_EN
      c_par        <= 1'b0;
`endif
    end else begin
      vld_pipe  <= {vld_pipe[0], issue};
      win_valid <= win_nx;
      if (issue) tag_s1 <= '{c: c_q, cm: cm_q};
      if (vld_pipe[0]) begin
        pixel_out    <= rd_data;
        col_ptr      <= tag_s1.cm;
        init_col_ptr <= (tag_s1.c >= AW'(KER_SIZE - 1)) ? KM1 : tag_s1.c[2:0];
`ifdef LB_FEEDER_STRIDE2_EN
        c_par        <= tag_s1.c[0];
`endif
      end
    end
  end

endmodule

// File: doc/line_buffer_feeder.md
# line_buffer_feeder

Column-stream generator that drives a K×K line-buffer window array. It walks an image in row bands of KER_SIZE rows, reading one KER_SIZE-pixel column per cycle from a column-read memory port. It presents each column on `pixel_out`, together with the rotating `col_ptr` and saturating `init_col_ptr` that the window array consumes, and flags each cycle in which the array's window register holds a new complete window. It sits between the feature-map SRAM and the line-buffer array in the convolution datapath.

## Interface
- KER_SIZE, 3: kernel size K; legal values 2..5.
- BITWIDTH, 8: bits per pixel.
- AW, 8: width of the image dimension, row and column fields.
- clk  in  1  clock.
- rstn  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle pulse; begins a frame. Ignored while busy.
- img_w  in  AW  image width in columns; latched on an accepted start.
- img_h  in  AW  image height in rows; latched on an accepted start.
- stall  in  1  blocks issue of new reads while high.
- rd_en  out  1  column read request.
- rd_row  out  AW  top row of the requested column.
- rd_col  out  AW  column index of the request.
- rd_data  in  BITWIDTH*KER_SIZE  returned column, valid exactly 1 cycle after rd_en. Slice j holds row rd_row+j.
- pixel_out  out  BITWIDTH*KER_SIZE  column presented to the window array.
- col_ptr  out  3  (c mod K) for the presented column.
- init_col_ptr  out  3  min(c, K-1) for the presented column.
- col_vld  out  1  a new column is presented this cycle.
- win_valid  out  1  the window array output register updated with a new full window this cycle.
- busy  out  1  frame in progress.
- done  out  1  one-cycle end-of-frame pulse.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE → RUN on start, provided img_w ≥ K and img_h ≥ K. Latch the dimensions and set r=0, c=0.
- IDLE → DONE on start if img_w < K or img_h < K. No reads and no windows are produced.
- RUN, each cycle with stall=0:
  - Assert rd_en with rd_row=r, rd_col=c.
  - Advance c; at c=img_w-1, wrap c to 0 and set r += 1.
  - After issuing the read (r, img_w-1) with r = img_h-K, go to DRAIN.
- RUN, stall=1: rd_en=0; r and c hold.
- DRAIN: no reads. Exit to DONE in the cycle after the last win_valid, or after 3 cycles if none is pending.
- DONE: done=1 for 1 cycle, then IDLE.
- Column pipeline: a read issued at cycle t with column c produces the following at cycle t+2, all registered:
  - pixel_out = rd_data captured at t+1.
  - col_ptr = c mod K.
  - init_col_ptr = min(c, K-1).
  - col_vld = 1.
- When no column returns, pixel_out, col_ptr and init_col_ptr hold their last values and col_vld=0. Re-presenting the same column is idempotent for the window array.
- At each new band (c=0), init_col_ptr returns to 0. This suppresses window capture until K columns of the new band have arrived.
- win_valid = col_vld & (init_col_ptr == K-1), delayed by 1 cycle. It is therefore aligned with the window array's registered output.
- Per frame: (img_h-K+1)·img_w reads and (img_h-K+1)·(img_w-K+1) win_valid pulses.
- The col_ptr counter is mod-K. It is never 5..7.

## Timing
- Reset values are 0 for all outputs; the FSM resets to IDLE.
- Latency:
  - start → first rd_en: 1 cycle.
  - rd_en → col_vld: 2 cycles.
  - col_vld (with init_col_ptr=K-1) → win_valid: 1 cycle.
- Throughput is 1 column per cycle with no bubbles at band boundaries.
- busy is high from the cycle after an accepted start through the DONE cycle inclusive.
- stall takes effect in the same cycle (combinational gate on rd_en). A read already issued still returns and is presented.
- start during busy is ignored, with no state change.
- start in the DONE cycle is ignored; start in the following IDLE cycle is accepted.
- rstn assertion mid-frame clears all state immediately, including the in-flight read. rd_data arriving after reset release is discarded.

## Configuration
- LB_FEEDER_STRIDE2_EN is defined: stride-2 mode.
  - The row step is 2; the last band has r ≤ img_h-K.
  - win_valid fires only for columns with (c-(K-1)) even.
  - Read count and column stream per band are unchanged.
- LB_FEEDER_STRIDE2_EN is undefined: stride 1 as described above.

## Test plan
- K=3, W=5, H=4, no stall → 10 rd_en:
  - (0,0..4) then (1,0..4).
  - col_ptr sequence 0,1,2,0,1 per band; init_col_ptr 0,1,2,2,2.
  - 6 win_valid pulses; done 1 cycle after the 6th.
- Same frame with stall high for 3 cycles mid-band → the column sequence is unchanged; col_vld gaps of 3 cycles; win_valid count still 6; outputs hold during the gap.
- img_w=2, K=3 start → no rd_en, no win_valid; busy and done each asserted for 1 cycle (the DONE cycle).
- start re-pulsed while busy → ignored; frame completes with 10 reads.
- rstn asserted after the 4th read → all outputs 0 next cycle; a new start gives a clean full frame.
- LB_FEEDER_STRIDE2_EN defined, K=3, W=5, H=4 → 5 reads (band r=0 only); win_valid for c=2 and c=4 only.
